cursor_input_ctrl: RTL and testbench

//  Upstream stage of the bubble-placement controller. Converts five raw push-buttons into a
//  6-bit cursor position on the 8x8 board (led = row*8 + col), a one-cycle placement pulse
//  (en) and the current player (turn). Rejects placements onto occupied cells using the red/blue

---
 rtl/cursor_input_ctrl_if.sv | 29 ++
 rtl/cursor_input_ctrl.sv | 167 ++++++++++++++++
 tb/tb_cursor_input_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cursor_input_ctrl_if.sv
// Signal bundle between the cursor input controller and its environment.
// master drives buttons and occupancy maps; slave is the controller itself.
interface cursor_input_ctrl_if;
  logic        btn_up;
  logic        btn_down;
  logic        btn_left;
  logic        btn_right;
  logic        btn_place;
  logic [63:0] red;
  logic [63:0] blue;
  logic [5:0]  led;
  logic        en;
  logic        turn;
  logic        reject;
  logic        cursor_vis;
  logic [1:0]  dbg_state;

  // en and reject are single-cycle strobes without back-pressure: the consumer
  // must act on the cycle they are high, and led is stable while en is high.
  modport master (
    output btn_up, btn_down, btn_left, btn_right, btn_place, red, blue,
    input  led, en, turn, reject, cursor_vis, dbg_state
  );

  modport slave (
    input  btn_up, btn_down, btn_left, btn_right, btn_place, red, blue,
    output led, en, turn, reject, cursor_vis, dbg_state
  );
endinterface

// File: rtl/cursor_input_ctrl.sv
// Push-button front end of the bubble-placement controller: debounce, cursor, place FSM.
// Optional macro CURSOR_BLINK_EN adds a blinking cursor_vis output.
module cursor_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int BLINK_CYCLES    = 12500000
) (
  input  logic CLK,
  input  logic reset,
  cursor_input_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLACE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  localparam int B_UP    = 0;
  localparam int B_DOWN  = 1;
  localparam int B_LEFT  = 2;
  localparam int B_RIGHT = 3;
  localparam int B_PLACE = 4;

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    db;
  logic [4:0]    press;
  logic [DW-1:0] db_cnt [5];

  state_t     state;
  state_t     state_next;
  logic [5:0] led;
  logic [5:0] led_next;
  logic       turn;
  logic       turn_next;
  logic       reject;
  logic       reject_next;
  logic       move_ok;
  logic       place_ok;
  logic       occupied;
  logic       full;

  assign raw = {bus.btn_place, bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

  // Counter runs only while the synchronised level disagrees with the accepted one.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      press <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      press <= '0;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          db[i]     <= sync2[i];
          press[i]  <= sync2[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign occupied = bus.red[led] | bus.blue[led];
  assign full     = &(bus.red | bus.blue);

  always_ff @(posedge CLK) begin
    if (!reset) begin
      state  <= IDLE;
      led    <= '0;
      turn   <= 1'b0;
      reject <= 1'b0;
    end else begin
      state  <= state_next;
      led    <= led_next;
      turn   <= turn_next;
      reject <= reject_next;
    end
  end

  // A place pulse outranks any move pulse arriving in the same cycle.
  always_comb begin
    state_next  = state;
    led_next    = led;
    turn_next   = turn;
    reject_next = 1'b0;
    move_ok     = 1'b0;
    place_ok    = 1'b0;
    case (state)
      IDLE: begin
        if (press[B_PLACE]) begin
          if (!occupied && !full) begin
            state_next = PLACE;
            place_ok   = 1'b1;
          end else begin
            reject_next = 1'b1;
          end
        end else if (press[B_UP]) begin
          led_next = {led[5:3] - 3'd1, led[2:0]};
          move_ok  = 1'b1;
        end else if (press[B_DOWN]) begin
          led_next = {led[5:3] + 3'd1, led[2:0]};
          move_ok  = 1'b1;
        end else if (press[B_LEFT]) begin
          led_next = {led[5:3], led[2:0] - 3'd1};
          move_ok  = 1'b1;
        end else if (press[B_RIGHT]) begin
          led_next = {led[5:3], led[2:0] + 3'd1};
          move_ok  = 1'b1;
        end
      end
      PLACE:   state_next = SETTLE;
      SETTLE: begin
        state_next = IDLE;
        turn_next  = ~turn;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.led       = led;
  assign bus.en        = (state == PLACE);
  assign bus.turn      = turn;
  assign bus.reject    = reject;
  assign bus.dbg_state = state;

`ifdef CURSOR_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;
  logic          vis;

  always_ff @(posedge CLK) begin
    if (!reset) begin
      blink_cnt <= '0;
      vis       <= 1'b1;
    end else if (move_ok || place_ok) begin
      blink_cnt <= '0;
      vis       <= 1'b1;
    end else if (blink_cnt == BL_LAST) begin
      blink_cnt <= '0;
      vis       <= ~vis;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign bus.cursor_vis = vis;
`else
  logic unused_ok;
  assign unused_ok      = move_ok ^ place_ok;
  assign bus.cursor_vis = 1'b1 | (BLINK_CYCLES != 0) | unused_ok;
`endif

endmodule

// File: tb/tb_cursor_input_ctrl.sv
// Directed bench for cursor_input_ctrl: expected events are queued as stimulus is
// issued and a negedge monitor pops and compares each observed event.
module tb_cursor_input_ctrl;

  localparam int DEB = 4;
  localparam int W   = 9;
  localparam logic [1:0] K_LED  = 2'd0;
  localparam logic [1:0] K_EN   = 2'd1;
  localparam logic [1:0] K_REJ  = 2'd2;
  localparam logic [1:0] K_TURN = 2'd3;
  localparam logic [4:0] M_UP    = 5'b00001;
  localparam logic [4:0] M_DOWN  = 5'b00010;
  localparam logic [4:0] M_LEFT  = 5'b00100;
  localparam logic [4:0] M_RIGHT = 5'b01000;
  localparam logic [4:0] M_PLACE = 5'b10000;

  logic clk;
  logic reset;
  logic mon_en;
  int   n_checks;
  int   n_fail;
  logic [W-1:0] exp_q[$];
  logic [5:0]   led_prev;
  logic         turn_prev;

  cursor_input_ctrl_if bus ();

  cursor_input_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES(8)
  ) dut (
    .CLK(clk),
    .reset(reset),
    .bus(bus)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] ev(input logic [1:0] kind, input logic t, input logic [5:0] l);
    return {kind, t, l};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic [4:0] m);
    bus.btn_up    = m[0];
    bus.btn_down  = m[1];
    bus.btn_left  = m[2];
    bus.btn_right = m[3];
    bus.btn_place = m[4];
  endtask

  task automatic press(input logic [4:0] m, input int hold);
    @(posedge clk); #1;
    drive(m);
    repeat (hold) @(posedge clk);
    #1;
    drive(5'b0);
    repeat (12) @(posedge clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  task automatic sb(input logic [W-1:0] got, input string name);
    logic [W-1:0] exp;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event got %0h expected none", name, got);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.led !== led_prev) sb(ev(K_LED, bus.turn, bus.led), "led_move");
      if (bus.en === 1'b1)      sb(ev(K_EN, bus.turn, bus.led), "en_strobe");
      if (bus.reject === 1'b1)  sb(ev(K_REJ, bus.turn, bus.led), "reject_pulse");
      if (bus.turn !== turn_prev) sb(ev(K_TURN, bus.turn, bus.led), "turn_toggle");
    end
    led_prev  = bus.led;
    turn_prev = bus.turn;
  end

  // ---------------- stimulus ----------------
  initial begin
    int  lat;
    bit  found;
    int  c1;
    int  c2;
    logic v0;
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    reset    = 1'b0;
    drive(5'b0);
    bus.red  = '0;
    bus.blue = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_led", bus.led, 0);
    check("reset_en", bus.en, 0);
    check("reset_turn", bus.turn, 0);
    check("reset_reject", bus.reject, 0);
    check("reset_vis", bus.cursor_vis, 1);
    check("reset_state", bus.dbg_state, 0);
    mon_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;

    // 1. held button moves once; eight rights wrap the column
    exp_q.push_back(ev(K_LED, 0, 6'd1));
    press(M_RIGHT, 20);
    @(negedge clk);
    check("hold_single_move", bus.led, 1);
    exp_q.push_back(ev(K_LED, 0, 6'd0));
    press(M_LEFT, 8);
    for (int i = 1; i <= 8; i++) begin
      exp_q.push_back(ev(K_LED, 0, 6'(i % 8)));
      press(M_RIGHT, 8);
    end
    @(negedge clk);
    check("col_wrap", bus.led, 0);

    // 2. row wrap up, with press-to-led latency, then back down
    exp_q.push_back(ev(K_LED, 0, 6'd56));
    @(posedge clk); #1;
    drive(M_UP);
    lat   = 0;
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.led == 6'd56) found = 1;
    end
    check("up_latency", lat, DEB + 3);
    @(posedge clk); #1;
    drive(5'b0);
    repeat (12) @(posedge clk);
    exp_q.push_back(ev(K_LED, 0, 6'd0));
    press(M_DOWN, 8);

    // 3. glitch shorter than debounce is ignored
    @(posedge clk); #1;
    drive(M_PLACE);
    repeat (3) @(posedge clk);
    #1;
    drive(5'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("glitch_led", bus.led, 0);
    check("glitch_turn", bus.turn, 0);

    // 4. accepted place at 9, then rejected on occupied cell
    exp_q.push_back(ev(K_LED, 0, 6'd8));
    press(M_DOWN, 8);
    exp_q.push_back(ev(K_LED, 0, 6'd9));
    press(M_RIGHT, 8);
    exp_q.push_back(ev(K_EN, 0, 6'd9));
    exp_q.push_back(ev(K_TURN, 1, 6'd9));
    press(M_PLACE, 8);
    @(negedge clk);
    check("turn_after_place", bus.turn, 1);
    bus.red = 64'h200;
    exp_q.push_back(ev(K_REJ, 1, 6'd9));
    press(M_PLACE, 8);

    // 5. up beats left; reset during SETTLE
    exp_q.push_back(ev(K_LED, 1, 6'd1));
    press(M_UP | M_LEFT, 8);
    exp_q.push_back(ev(K_EN, 1, 6'd1));
    @(posedge clk); #1;
    drive(M_PLACE);
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.en === 1'b1) found = 1;
    end
    check("en_seen_before_reset", found, 1);
    exp_q.push_back(ev(K_LED, 0, 6'd0));
    exp_q.push_back(ev(K_TURN, 0, 6'd0));
    @(posedge clk); #1;
    check("in_settle", bus.dbg_state, 2);
    reset = 1'b0;
    @(posedge clk); #1;
    drive(5'b0);
    @(negedge clk);
    check("settle_reset_led", bus.led, 0);
    check("settle_reset_turn", bus.turn, 0);
    check("settle_reset_en", bus.en, 0);
    check("settle_reset_state", bus.dbg_state, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (15) @(posedge clk);

    // 6. full board and occupied-by-blue rejects
    bus.red  = '1;
    bus.blue = '0;
    exp_q.push_back(ev(K_REJ, 0, 6'd0));
    press(M_PLACE, 8);
    bus.red  = '0;
    bus.blue = '1;
    exp_q.push_back(ev(K_REJ, 0, 6'd0));
    press(M_PLACE, 8);
    bus.red  = 64'h5555_5555_5555_5555;
    bus.blue = 64'hAAAA_AAAA_AAAA_AAAA;
    exp_q.push_back(ev(K_REJ, 0, 6'd0));
    press(M_PLACE, 8);
    bus.red  = '0;
    bus.blue = 64'h1;
    exp_q.push_back(ev(K_REJ, 0, 6'd0));
    press(M_PLACE, 8);

`ifdef CURSOR_BLINK_EN
    @(negedge clk);
    v0 = bus.cursor_vis;
    for (int i = 0; i < 30 && bus.cursor_vis == v0; i++) @(negedge clk);
    v0 = bus.cursor_vis;
    c1 = 0;
    for (int i = 0; i < 30 && bus.cursor_vis == v0; i++) begin
      @(negedge clk);
      c1++;
    end
    v0 = bus.cursor_vis;
    c2 = 0;
    for (int i = 0; i < 30 && bus.cursor_vis == v0; i++) begin
      @(negedge clk);
      c2++;
    end
    check("blink_period_a", c1, 8);
    check("blink_period_b", c2, 8);
`else
    c1 = 0;
    c2 = 0;
    v0 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.cursor_vis !== 1'b1) c1++;
    end
    check("vis_tied_high", c1, c2);
    check("vis_level", bus.cursor_vis, v0);
`endif

    repeat (10) @(posedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
